// File: rtl/riscv_fetch_pkg.sv
// Shared widths, constants and the fetch queue entry layout for the fetch front end.
package riscv_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;
  localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch is word granular; the two byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over push and pop; the head is read combinationally.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [XLEN-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [XLEN-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {push_pc, push_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the fetch PC, drives instruction memory, queues words for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic               fetch_fault
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  // Handshake: a queue entry moves to decode on a rising edge where out_valid
  // and out_ready are both high; out_valid never depends on out_ready.
  logic [XLEN-1:0]  fpc;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             halted;

  assign imem_addr = fpc;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && !halted &&
                     ((count != CNT_W'(QUEUE_DEPTH)) || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= align_pc(redirect_pc);
    end else if (push) begin
      fpc <= fpc + PC_STEP;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until the next redirect; every redirect re-evaluates alignment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      fetch_fault <= (redirect_pc[1:0] != 2'b00);
    end
  end
  assign halted = fetch_fault;
`else
  assign fetch_fault = 1'b0;
  assign halted      = 1'b0;
`endif

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (fpc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed sequences plus random ready/redirect traffic,
// checked against a stream model of expected {pc, instr} pairs.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          STREAM_LEN = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  logic [31:0] imem [0:1023];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          handshakes = 0;

  assign imem_rdata = imem[imem_addr[11:2]];

  instruction_fetch #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers / model ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decode must see consecutive words starting at the target, wrapping at 2^32.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int k = 0; k < STREAM_LEN; k++) begin
      exp_q.push_back({p, imem[p[11:2]]});
      p = p + 32'd4;
    end
  endtask

  // Issues a one-cycle redirect; returns #1 after the edge that consumed it.
  task automatic do_redirect(input logic [31:0] tgt);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (tgt[1:0] == 2'b00) load_stream(tgt);
    else exp_q.delete();
`else
    load_stream({tgt[31:2], 2'b00});
`endif
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int target;
    int cyc;
    target = handshakes + n;
    cyc = 0;
    while (handshakes < target && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (handshakes < target) begin
      errors++;
      $display("FAIL hs_timeout: got %0d handshakes expected %0d", handshakes, target);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && out_valid && out_ready && !redirect_valid) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got pc %h expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("stream", {out_pc, out_instr}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[0] = 32'h2008_0005;
    imem[1] = 32'h2009_0003;
    imem[2] = 32'h0109_5020;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_addr", imem_addr, RESET_PC);

    // Release with decode ready: words at 0x0, 0x4, 0x8 on consecutive cycles
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    load_stream(RESET_PC);
    @(posedge clk); #1;
    check("first_valid", out_valid, 1);
    check("first_pc", out_pc, 32'h0);
    check("first_instr", out_instr, 32'h2008_0005);
    @(posedge clk); #1;
    check("second_pc", out_pc, 32'h4);
    @(posedge clk); #1;
    check("third_pc", out_pc, 32'h8);
    check("third_instr", out_instr, 32'h0109_5020);

    // Async reset with entries queued
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("prerst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_addr", imem_addr, RESET_PC);
    repeat (2) @(posedge clk);

    // Restart under stall: queue saturates, fetch PC holds
    @(negedge clk);
    rst = 1'b1;
    load_stream(RESET_PC);
    repeat (6) @(posedge clk);
    #1;
    check("stall_addr", imem_addr, 32'h8);
    check("stall_head_pc", out_pc, 32'h0);
    check("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_hs(3);

    // Redirect while full: old entries must never appear
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    do_redirect(32'h40);
    check("redir_valid", out_valid, 0);
    check("redir_addr", imem_addr, 32'h40);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("redir_target_valid", out_valid, 1);
    check("redir_target_pc", out_pc, 32'h40);
    wait_hs(3);

    // Address wrap-around
    do_redirect(32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap_pc", out_pc, 32'hFFFF_FFF8);
    wait_hs(4);

    // Misaligned redirect
    do_redirect(32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", fetch_fault, 1);
    repeat (4) @(posedge clk);
    #1;
    check("mis_halt_valid", out_valid, 0);
    check("mis_halt_addr", imem_addr, 32'h40);
    check("mis_fault_sticky", fetch_fault, 1);
    do_redirect(32'h80);
    check("mis_fault_clear", fetch_fault, 0);
    @(posedge clk); #1;
    check("mis_resume_pc", out_pc, 32'h80);
    wait_hs(3);
`else
    check("mis_nofault", fetch_fault, 0);
    @(posedge clk); #1;
    check("mis_align_pc", out_pc, 32'h40);
    wait_hs(3);
`endif

    // Random ready and redirect traffic
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        load_stream(redirect_pc);
`else
        redirect_pc = $urandom;
        load_stream({redirect_pc[31:2], 2'b00});
`endif
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    wait_hs(4);
    check("fault_end", fetch_fault, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
